// File: rtl/dlfloat_operand_loader_if.sv
// Host/MAC-side signal bundle of the DLFloat16 operand loader.
// The master modport is the host and MAC side; the slave modport is the loader itself.
interface dlfloat_operand_loader_if #(
   parameter int DEPTH = 4,
   parameter int W     = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [7:0]    byte_in;
   logic          byte_valid;
   logic          flush;
   logic          op_ready;
   logic          op_valid;
   logic [W-1:0]  op_a;
   logic [W-1:0]  op_b;
   logic [CW-1:0] count;
   logic          full;
   logic          overflow;

   modport master (
      output byte_in, byte_valid, flush, op_ready,
      input  op_valid, op_a, op_b, count, full, overflow
   );

   modport slave (
      input  byte_in, byte_valid, flush, op_ready,
      output op_valid, op_a, op_b, count, full, overflow
   );
endinterface

// File: rtl/dlfloat_operand_loader.sv
// Packs the pad byte stream into DLFloat16 {A,B} pairs and buffers them in a show-ahead
// FIFO that feeds the MAC through a valid/ready handshake.
module dlfloat_operand_loader #(
   parameter int DEPTH = 4,
   parameter int W     = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   dlfloat_operand_loader_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   localparam logic [1:0] S_A0 = 2'd0;
   localparam logic [1:0] S_A1 = 2'd1;
   localparam logic [1:0] S_B0 = 2'd2;
   localparam logic [1:0] S_B1 = 2'd3;

   logic [1:0]     state;
   logic [7:0]     a_lo;
   logic [7:0]     a_hi;
   logic [7:0]     b_lo;
   logic [2*W-1:0] mem [DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [CW-1:0]  count_q;
   logic           overflow_q;
   logic           empty;
   logic           full_w;
   logic           push_req;
   logic           push;
   logic           pop;

   // A full FIFO still accepts a pair when the head is leaving on the same edge.
   always_comb begin
      empty    = (count_q == '0);
      full_w   = (count_q == CW'(DEPTH));
      pop      = !bus.flush && !empty && bus.op_ready;
      push_req = !bus.flush && bus.byte_valid && (state == S_B1);
      push     = push_req && (!full_w || pop);
   end

   // NOTE: state registers use non-blocking assignments so every always_ff samples the
   // pre-edge values; blocking here would create order-dependent simulation races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_A0;
         a_lo  <= '0;
         a_hi  <= '0;
         b_lo  <= '0;
      end else if (bus.flush) begin
         state <= S_A0;
      end else if (bus.byte_valid) begin
         case (state)
            S_A0:    begin a_lo <= bus.byte_in; state <= S_A1; end
            S_A1:    begin a_hi <= bus.byte_in; state <= S_B0; end
            S_B0:    begin b_lo <= bus.byte_in; state <= S_B1; end
            default: state <= S_A0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else if (bus.flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
         if (push_req && !push) overflow_q <= 1'b1;
      end
   end

   // NOTE: the storage array has no reset; stale entries are never visible because the
   // outputs are gated by empty, and leaving it unreset lets it map onto plain RAM cells.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {a_hi, a_lo, bus.byte_in, b_lo};
   end

   // NOTE: every output gets a default before the conditional so no latch is inferred.
   always_comb begin
      bus.op_a = '0;
      bus.op_b = '0;
      if (!empty) begin
         bus.op_a = mem[rd_ptr][2*W-1:W];
         bus.op_b = mem[rd_ptr][W-1:0];
      end
      bus.op_valid = !empty;
      bus.count    = count_q;
      bus.full     = full_w;
      bus.overflow = overflow_q;
   end
endmodule

// File: tb/tb_dlfloat_operand_loader.sv
// Directed bench for dlfloat_operand_loader: assembly, FIFO fill/overflow, concurrent
// push/pop at full, streaming with pointer wrap, flush and asynchronous reset.
module tb_dlfloat_operand_loader;
   localparam int DEPTH = 4;
   localparam int W     = 16;

   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   dlfloat_operand_loader_if #(.DEPTH(DEPTH), .W(W)) bus ();

   dlfloat_operand_loader #(.DEPTH(DEPTH), .W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic rdy);
      bus.byte_in    = b;
      bus.byte_valid = 1'b1;
      bus.op_ready   = rdy;
      @(posedge clk);
      #1;
      bus.byte_valid = 1'b0;
      bus.op_ready   = 1'b0;
   endtask

   task automatic send_pair(input logic [15:0] a, input logic [15:0] b,
                            input logic rdy_first, input logic rdy_last);
      send_byte(a[7:0], rdy_first);
      send_byte(a[15:8], 1'b0);
      send_byte(b[7:0], 1'b0);
      send_byte(b[15:8], rdy_last);
   endtask

   task automatic idle(input logic rdy);
      bus.op_ready = rdy;
      @(posedge clk);
      #1;
      bus.op_ready = 1'b0;
   endtask

   task automatic check_head(input string tag, input logic v, input logic [15:0] a,
                             input logic [15:0] b, input int cnt);
      chk({tag, ".valid"}, 32'(bus.op_valid), 32'(v));
      chk({tag, ".a"},     32'(bus.op_a),     32'(a));
      chk({tag, ".b"},     32'(bus.op_b),     32'(b));
      chk({tag, ".count"}, 32'(bus.count),    32'(cnt));
   endtask

   initial begin
      rst_n          = 1'b0;
      bus.byte_in    = 8'h00;
      bus.byte_valid = 1'b0;
      bus.flush      = 1'b0;
      bus.op_ready   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_head("reset", 1'b0, 16'h0000, 16'h0000, 0);
      chk("reset.full", 32'(bus.full), 32'd0);
      chk("reset.ovf",  32'(bus.overflow), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: single pair assembly, one cycle latency from the last byte
      send_byte(8'h00, 1'b0);
      send_byte(8'h3E, 1'b0);
      send_byte(8'h00, 1'b0);
      chk("t1.partial_valid", 32'(bus.op_valid), 32'd0);
      send_byte(8'h40, 1'b0);
      check_head("t1", 1'b1, 16'h3E00, 16'h4000, 1);

      // 2: fill to DEPTH, fifth pair dropped
      send_pair(16'h1111, 16'h2222, 1'b0, 1'b0);
      send_pair(16'h3333, 16'h4444, 1'b0, 1'b0);
      chk("t2.not_full", 32'(bus.full), 32'd0);
      send_pair(16'h5555, 16'h6666, 1'b0, 1'b0);
      chk("t2.full", 32'(bus.full), 32'd1);
      chk("t2.ovf_before", 32'(bus.overflow), 32'd0);
      send_pair(16'h7777, 16'h8888, 1'b0, 1'b0);
      chk("t2.ovf", 32'(bus.overflow), 32'd1);
      check_head("t2.head", 1'b1, 16'h3E00, 16'h4000, 4);

      // flush clears the sticky flag before the concurrent push/pop case
      bus.flush = 1'b1;
      idle(1'b0);
      bus.flush = 1'b0;
      check_head("flush1", 1'b0, 16'h0000, 16'h0000, 0);
      chk("flush1.ovf", 32'(bus.overflow), 32'd0);

      // 3: push and pop on the same edge while full
      send_pair(16'h0001, 16'h0002, 1'b0, 1'b0);
      send_pair(16'h0003, 16'h0004, 1'b0, 1'b0);
      send_pair(16'h0005, 16'h0006, 1'b0, 1'b0);
      send_pair(16'h0007, 16'h0008, 1'b0, 1'b0);
      chk("t3.full", 32'(bus.full), 32'd1);
      send_pair(16'h0009, 16'h000A, 1'b0, 1'b1);
      check_head("t3", 1'b1, 16'h0003, 16'h0004, 4);
      chk("t3.ovf", 32'(bus.overflow), 32'd0);
      idle(1'b1);
      check_head("t3.pop1", 1'b1, 16'h0005, 16'h0006, 3);
      idle(1'b1);
      check_head("t3.pop2", 1'b1, 16'h0007, 16'h0008, 2);
      idle(1'b1);
      check_head("t3.pop3", 1'b1, 16'h0009, 16'h000A, 1);
      idle(1'b1);
      check_head("t3.drained", 1'b0, 16'h0000, 16'h0000, 0);

      // 4: streaming with op_ready every cycle wraps both pointers
      for (int i = 0; i < 8; i++) begin
         send_pair(16'hA000 + 16'(i), 16'hB000 + 16'(i), 1'b1, 1'b1);
         check_head($sformatf("t4.p%0d", i), 1'b1, 16'hA000 + 16'(i), 16'hB000 + 16'(i), 1);
      end
      idle(1'b1);
      check_head("t4.empty", 1'b0, 16'h0000, 16'h0000, 0);

      // 5: flush discards partial bytes and ignores a same-cycle byte
      send_byte(8'h12, 1'b0);
      send_byte(8'h34, 1'b0);
      bus.flush = 1'b1;
      send_byte(8'h55, 1'b1);
      bus.flush = 1'b0;
      chk("t5.flush_count", 32'(bus.count), 32'd0);
      send_pair(16'hFFFF, 16'h0000, 1'b0, 1'b0);
      check_head("t5", 1'b1, 16'hFFFF, 16'h0000, 1);

      // 6: asynchronous reset mid-burst
      send_pair(16'h1234, 16'h5678, 1'b0, 1'b0);
      send_pair(16'h9ABC, 16'hDEF0, 1'b0, 1'b0);
      chk("t6.count3", 32'(bus.count), 32'd3);
      send_byte(8'h77, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_head("t6.rst", 1'b0, 16'h0000, 16'h0000, 0);
      chk("t6.rst_full", 32'(bus.full), 32'd0);
      chk("t6.rst_ovf",  32'(bus.overflow), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      send_pair(16'hC0DE, 16'hBEEF, 1'b0, 1'b0);
      check_head("t6.after", 1'b1, 16'hC0DE, 16'hBEEF, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
